// File: rtl/fir_decim_out.sv
// fir_decim_out: drops FIR pipeline-fill samples, decimates by DECIM,
// rounds/saturates to OUT_W bits and buffers in a show-ahead FIFO drained
// through a valid/ready handshake.
module fir_decim_out #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 16,
  parameter int SHIFT = 15,
  parameter int DECIM = 4,
  parameter int SKIP  = 19,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic [IN_W-1:0]  fir_in,
  input  logic             in_valid,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sat_flag,
  output logic             ovf_flag,
  input  logic             flag_clr
);

  localparam int AW   = $clog2(DEPTH);
  localparam int SK_W = (SKIP > 0) ? $clog2(SKIP + 1) : 1;
  localparam int PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [IN_W:0] RND = (IN_W + 1)'(1) << (SHIFT - 1);

  logic [SK_W-1:0]  skip_q, skip_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic             stg_vld_q, stg_vld_d;
  logic [OUT_W-1:0] stg_data_q, stg_data_d;
  logic             sat_q, sat_d;
  logic             ovf_q, ovf_d;
  logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic [OUT_W-1:0] mem_q [DEPTH];
  logic [OUT_W-1:0] mem_d [DEPTH];

  logic             skipping, keep, clamp;
  logic [IN_W:0]    ext;
  logic signed [IN_W:0] shr;
  logic [OUT_W-1:0] rounded;
  logic             empty, full, rd, wr, drop;

  // Skip/phase counting: only accepted samples move either counter.
  always_comb begin
    skip_d   = skip_q;
    phase_d  = phase_q;
    skipping = (skip_q != SK_W'(SKIP));
    keep     = in_valid && !skipping && (phase_q == '0);
    if (in_valid) begin
      if (skipping)
        skip_d = skip_q + SK_W'(1);
      else if (phase_q == PH_W'(DECIM - 1))
        phase_d = '0;
      else
        phase_d = phase_q + PH_W'(1);
    end
  end

  // Round half toward +inf, then clamp when the bits above the output sign
  // are not a pure sign extension.
  always_comb begin
    ext     = {fir_in[IN_W-1], fir_in} + RND;
    shr     = $signed(ext) >>> SHIFT;
    clamp   = !((&shr[IN_W:OUT_W-1]) || (~|shr[IN_W:OUT_W-1]));
    rounded = shr[OUT_W-1:0];
    if (clamp)
      rounded = shr[IN_W] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    stg_vld_d  = keep;
    stg_data_d = keep ? rounded : stg_data_q;
  end

  // FIFO control and sticky flags; a same-cycle set beats flag_clr.
  always_comb begin
    empty = (wptr_q == rptr_q);
    full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    rd    = !empty && out_ready;
    wr    = stg_vld_q && (!full || rd);
    drop  = stg_vld_q && full && !rd;
    mem_d = mem_q;
    if (wr)
      mem_d[wptr_q[AW-1:0]] = stg_data_q;
    wptr_d = wptr_q + (AW + 1)'(wr);
    rptr_d = rptr_q + (AW + 1)'(rd);
    sat_d  = (keep && clamp) || (sat_q && !flag_clr);
    ovf_d  = drop || (ovf_q && !flag_clr);
  end

  // Control state, all cleared asynchronously.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      skip_q     <= '0;
      phase_q    <= '0;
      stg_vld_q  <= 1'b0;
      stg_data_q <= '0;
      sat_q      <= 1'b0;
      ovf_q      <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
    end else begin
      skip_q     <= skip_d;
      phase_q    <= phase_d;
      stg_vld_q  <= stg_vld_d;
      stg_data_q <= stg_data_d;
      sat_q      <= sat_d;
      ovf_q      <= ovf_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
    end
  end

  // FIFO storage carries no reset; empty entries are masked at the output.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign out_valid = !empty;
  assign out_data  = empty ? '0 : mem_q[rptr_q[AW-1:0]];
  assign sat_flag  = sat_q;
  assign ovf_flag  = ovf_q;

endmodule

// File: tb/tb_fir_decim_out.sv
// Bench for fir_decim_out: three configurations share one stimulus stream
// and are checked every cycle against an accepted-count based model.
module tb_fir_decim_out;

  int SKP [3] = '{19, 0, 0};
  int DCM [3] = '{4, 1, 2};
  localparam int DEP = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] fir_in = '0;
  logic        in_valid = 1'b0, out_ready = 1'b0, flag_clr = 1'b0;
  logic [15:0] od [3];
  logic        ov [3];
  logic        sf [3];
  logic        of [3];

  fir_decim_out #(.SKIP(19), .DECIM(4)) u_a (.clk(clk), .Reset(rst), .fir_in(fir_in),
    .in_valid(in_valid), .out_data(od[0]), .out_valid(ov[0]), .out_ready(out_ready),
    .sat_flag(sf[0]), .ovf_flag(of[0]), .flag_clr(flag_clr));
  fir_decim_out #(.SKIP(0), .DECIM(1)) u_b (.clk(clk), .Reset(rst), .fir_in(fir_in),
    .in_valid(in_valid), .out_data(od[1]), .out_valid(ov[1]), .out_ready(out_ready),
    .sat_flag(sf[1]), .ovf_flag(of[1]), .flag_clr(flag_clr));
  fir_decim_out #(.SKIP(0), .DECIM(2)) u_c (.clk(clk), .Reset(rst), .fir_in(fir_in),
    .in_valid(in_valid), .out_data(od[2]), .out_valid(ov[2]), .out_ready(out_ready),
    .sat_flag(sf[2]), .ovf_flag(of[2]), .flag_clr(flag_clr));

  always #5 clk = ~clk;

  // model state
  int acc [3];
  bit mst_v [3];
  int mst_d [3];
  bit msat [3];
  bit movf [3];
  int fm [3][DEP];
  int fc [3];
  int snk [3][64];
  int ns [3];
  int cyc;
  int n_cmp = 0, n_bad = 0;

  int rv [4] = '{32'h0000_8000, 32'h0000_4000, 32'hFFFF_C000, 32'hFFFF_7FFF};
  int re [4] = '{16'h0001, 16'h0001, 16'h0000, 16'hFFFF};
  int bpx [5] = '{1, 2, 3, 4, 7};

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  // floor((x + 2^14) / 2^15) clamped to int16, returned as 16-bit pattern
  function automatic int rnd(input logic [31:0] x, output bit c);
    longint v, q;
    v = longint'($signed(x)) + 64'sd16384;
    if (v >= 0) q = v / 32768;
    else        q = -((-v + 32767) / 32768);
    c = 1'b0;
    if (q > 32767)  begin q = 32767;  c = 1'b1; end
    if (q < -32768) begin q = -32768; c = 1'b1; end
    return int'(q) & 32'hFFFF;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 3; k++) begin
      acc[k] = 0; mst_v[k] = 0; mst_d[k] = 0; msat[k] = 0; movf[k] = 0; fc[k] = 0; ns[k] = 0;
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("out_valid[%0d]", k), int'(ov[k]), int'(fc[k] > 0));
      if (fc[k] > 0) chk($sformatf("out_data[%0d]", k), int'(od[k]), fm[k][0]);
      chk($sformatf("sat_flag[%0d]", k), int'(sf[k]), int'(msat[k]));
      chk($sformatf("ovf_flag[%0d]", k), int'(of[k]), int'(movf[k]));
    end
  endtask

  // One clock: record sink transfers, advance the model, check at negedge.
  task automatic step();
    bit iv, r, c, kept, cl, oe, pop;
    logic [31:0] x;
    int d;
    for (int k = 0; k < 3; k++)
      if (ov[k] && out_ready && ns[k] < 64) begin snk[k][ns[k]] = int'(od[k]); ns[k]++; end
    iv = in_valid; r = out_ready; c = flag_clr; x = fir_in;
    @(posedge clk);
    cyc++;
    for (int k = 0; k < 3; k++) begin
      oe  = 1'b0;
      pop = (fc[k] > 0) && r;
      if (pop) begin
        for (int j = 0; j < DEP - 1; j++) fm[k][j] = fm[k][j+1];
        fc[k]--;
      end
      if (mst_v[k]) begin
        if (fc[k] < DEP) begin fm[k][fc[k]] = mst_d[k]; fc[k]++; end
        else oe = 1'b1;
      end
      kept = iv && (acc[k] >= SKP[k]) && (((acc[k] - SKP[k]) % DCM[k]) == 0);
      d = rnd(x, cl);
      msat[k]  = (kept && cl) ? 1'b1 : (c ? 1'b0 : msat[k]);
      movf[k]  = oe ? 1'b1 : (c ? 1'b0 : movf[k]);
      mst_v[k] = kept;
      mst_d[k] = d;
      if (iv) acc[k]++;
    end
    @(negedge clk);
    compare_all();
  endtask

  // Asynchronous reset asserted mid low-phase; outputs must drop at once.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_data[%0d]", k), int'(od[k]), 0);
      chk($sformatf("rst_valid[%0d]", k), int'(ov[k]), 0);
      chk($sformatf("rst_sat[%0d]", k), int'(sf[k]), 0);
      chk($sformatf("rst_ovf[%0d]", k), int'(of[k]), 0);
    end
    model_clear();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int c19, first;
    cyc = 0;
    model_clear();
    do_reset();

    // rounding, DECIM=1 SKIP=0 instance
    out_ready = 1'b1;
    for (int i = 0; i <= 4; i++) begin
      if (i < 4) begin in_valid = 1'b1; fir_in = rv[i]; end
      else in_valid = 1'b0;
      step();
      if (i >= 1) chk("round", int'(od[1]), re[i-1]);
      chk("round_nosat", int'(sf[1]), 0);
    end

    // saturation and sticky flag behaviour
    in_valid = 1'b1; fir_in = 32'h7FFF_FFFF; step();
    chk("sat_rise", int'(sf[1]), 1);
    fir_in = 32'h8000_0000; step();
    chk("sat_max", int'(od[1]), 16'h7FFF);
    in_valid = 1'b0; step();
    chk("sat_min", int'(od[1]), 16'h8000);
    flag_clr = 1'b1; step();
    chk("sat_clr", int'(sf[1]), 0);
    in_valid = 1'b1; fir_in = 32'h7FFF_FFFF; step();
    chk("sat_set_wins", int'(sf[1]), 1);
    in_valid = 1'b0; flag_clr = 1'b0; step(); step();

    // backpressure into a 4-entry FIFO
    do_reset();
    out_ready = 1'b0;
    for (int n = 1; n <= 6; n++) begin in_valid = 1'b1; fir_in = n << 15; step(); end
    in_valid = 1'b0; step();
    chk("bp_ovf", int'(of[1]), 1);
    chk("bp_head", int'(od[1]), 1);
    flag_clr = 1'b1; step(); flag_clr = 1'b0;
    chk("bp_ovf_clr", int'(of[1]), 0);
    in_valid = 1'b1; fir_in = 7 << 15; step();
    in_valid = 1'b0; out_ready = 1'b1; ns[1] = 0;
    for (int i = 0; i < 6; i++) step();
    chk("bp_ovf_none", int'(of[1]), 0);
    chk("bp_count", ns[1], 5);
    for (int i = 0; i < 5; i++) chk($sformatf("bp_sink%0d", i), snk[1][i], bpx[i]);

    // reset mid-stream with 3 entries buffered
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin in_valid = 1'b1; fir_in = i << 15; step(); end
    in_valid = 1'b0; step(); step(); step();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin in_valid = 1'b1; fir_in = (100 + i) << 15; step(); end
    in_valid = 1'b0; step();
    chk("mid_buffered", fc[1], 3);
    chk("mid_valid", int'(ov[1]), 1);
    do_reset();

    // skip and decimation restart on the SKIP=19 DECIM=4 instance
    out_ready = 1'b1; c19 = -1; first = -1;
    for (int i = 0; i <= 40; i++) begin
      in_valid = 1'b1; fir_in = i << 15;
      step();
      if (i == 19) c19 = cyc;
      if (ov[0] && first < 0) first = cyc;
    end
    in_valid = 1'b0; step(); step();
    chk("first_valid_cycle", first - c19, 1);
    chk("skip_count", int'(ns[0] >= 4), 1);
    for (int i = 0; i < 4; i++) chk($sformatf("skip_out%0d", i), snk[0][i], 19 + 4 * i);

    // in_valid gaps on the DECIM=2 instance
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_valid = (i % 2 == 0);
      fir_in = in_valid ? ((i / 2) << 15) : 32'h1234_5678;
      step();
    end
    in_valid = 1'b0; step(); step(); step();
    chk("gap_count", ns[2], 4);
    for (int i = 0; i < 4; i++) chk($sformatf("gap_out%0d", i), snk[2][i], 2 * i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
